// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: issue, ALU and multi-cycle result inputs, decode hazard query,
// register file write port and scoreboard. WB_FWD_EN adds the forwarding outputs.
interface wb_arbiter_if #(
   parameter int unsigned XLEN = 64
);
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            mem_valid;
   logic            mem_ready;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_data;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      chk_rd;
   logic            hazard;
   logic            wen;
   logic [4:0]      rd;
   logic [XLEN-1:0] result;
   logic [31:0]     busy;
`ifdef WB_FWD_EN
   logic            fwd1_hit;
   logic            fwd2_hit;
   logic [XLEN-1:0] fwd1_data;
   logic [XLEN-1:0] fwd2_data;
`endif

   modport master (
      output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data, rs1, rs2, chk_rd,
      input  mem_ready, hazard, wen, rd, result, busy
`ifdef WB_FWD_EN
      , input fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
   );

   modport slave (
      input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data, rs1, rs2, chk_rd,
      output mem_ready, hazard, wen, rd, result, busy
`ifdef WB_FWD_EN
      , output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
   );
endinterface

// File: rtl/wb_arbiter.sv
// Register file write-side arbiter: ALU results win, multi-cycle results queue in a FIFO,
// busy scoreboard drives the decode hazard. Optional macro WB_FWD_EN adds write-stage forwarding.
module wb_arbiter #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 2
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave wb
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [4:0]      fifo_rd_q   [DEPTH];
   logic [XLEN-1:0] fifo_data_q [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            fifo_full, fifo_empty, push, pop;
   logic            sel_valid;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            wen_q, wen_d, memsrc_q, memsrc_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [31:0]     busy_q, busy_d, haz_busy;
   logic            hazard_c;

   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign wb.mem_ready = rst && !fifo_full;
   assign push = wb.mem_valid && wb.mem_ready;

   // Select source, stage the write and update pointers/scoreboard
   always_comb begin
      pop       = !wb.alu_valid && !fifo_empty;
      sel_valid = wb.alu_valid || !fifo_empty;
      sel_rd    = wb.alu_valid ? wb.alu_rd   : fifo_rd_q[rd_ptr_q[AW-1:0]];
      sel_data  = wb.alu_valid ? wb.alu_data : fifo_data_q[rd_ptr_q[AW-1:0]];
      wen_d     = sel_valid && (sel_rd != 5'd0);
      memsrc_d  = pop && (sel_rd != 5'd0);
      rd_d      = wen_d ? sel_rd   : rd_q;
      result_d  = wen_d ? sel_data : result_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      busy_d    = busy_q;
      if (memsrc_q) busy_d[rd_q] = 1'b0;
      // A new issue to the index being retired keeps it busy
      if (wb.issue_valid && (wb.issue_rd != 5'd0)) busy_d[wb.issue_rd] = 1'b1;
   end

   always_comb begin
      haz_busy = busy_q;
`ifdef WB_FWD_EN
      // Source operands retiring this cycle are served by the forward path
      if (memsrc_q) haz_busy[rd_q] = 1'b0;
`endif
      hazard_c = ((wb.rs1 != 5'd0) && haz_busy[wb.rs1]) ||
                 ((wb.rs2 != 5'd0) && haz_busy[wb.rs2]) ||
                 ((wb.chk_rd != 5'd0) && busy_q[wb.chk_rd]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wen_q    <= 1'b0;
         memsrc_q <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
         busy_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wen_q    <= wen_d;
         memsrc_q <= memsrc_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   // Storage needs no reset: pointers define validity, push is blocked in reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q[AW-1:0]]   <= wb.mem_rd;
         fifo_data_q[wr_ptr_q[AW-1:0]] <= wb.mem_data;
      end
   end

   assign wb.hazard = hazard_c;
   assign wb.wen    = wen_q;
   assign wb.rd     = rd_q;
   assign wb.result = result_q;
   assign wb.busy   = busy_q;

`ifdef WB_FWD_EN
   assign wb.fwd1_hit  = wen_q && (rd_q == wb.rs1) && (wb.rs1 != 5'd0);
   assign wb.fwd2_hit  = wen_q && (rd_q == wb.rs2) && (wb.rs2 != 5'd0);
   assign wb.fwd1_data = result_q;
   assign wb.fwd2_data = result_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Build with WB_FWD_EN to cover forwarding.
module tb_wb_arbiter;
   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   wb_arbiter_if #(.XLEN(XLEN)) bus ();
   wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .wb(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   ent_t            mq[$];
   logic [31:0]     m_busy;
   logic            m_wen;
   logic            m_mem;
   logic [4:0]      m_rd;
   logic [XLEN-1:0] m_res;
   logic [4:0]      pend[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_hazard();
      logic [31:0] bs;
      bs = m_busy;
`ifdef WB_FWD_EN
      if (m_wen && m_mem) bs[m_rd] = 1'b0;
`endif
      return ((bus.rs1 != 5'd0) && bs[bus.rs1]) || ((bus.rs2 != 5'd0) && bs[bus.rs2]) ||
             ((bus.chk_rd != 5'd0) && m_busy[bus.chk_rd]);
   endfunction

   task automatic idle_inputs();
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = 5'd0;
      bus.alu_data    = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_rd      = 5'd0;
      bus.mem_data    = '0;
      bus.rs1         = 5'd0;
      bus.rs2         = 5'd0;
      bus.chk_rd      = 5'd0;
   endtask

   // Combinational outputs against the model, inputs already driven
   task automatic comb_check();
      #1;
      check_eq("mem_ready", 64'(bus.mem_ready), 64'(rst && (mq.size() < DEPTH)));
      check_eq("hazard", 64'(bus.hazard), 64'(exp_hazard()));
`ifdef WB_FWD_EN
      check_eq("fwd1_hit", 64'(bus.fwd1_hit), 64'(m_wen && (m_rd == bus.rs1) && (bus.rs1 != 5'd0)));
      check_eq("fwd2_hit", 64'(bus.fwd2_hit), 64'(m_wen && (m_rd == bus.rs2) && (bus.rs2 != 5'd0)));
      check_eq("fwd1_data", 64'(bus.fwd1_data), 64'(m_res));
`endif
   endtask

   task automatic model_edge();
      logic [31:0]     nb;
      logic            sel;
      logic            pop;
      logic            push;
      logic [4:0]      srd;
      logic [XLEN-1:0] sd;
      ent_t            e;
      if (!rst) begin
         mq.delete();
         m_busy = '0;
         m_wen  = 1'b0;
         m_mem  = 1'b0;
         m_rd   = 5'd0;
         m_res  = '0;
         return;
      end
      push = bus.mem_valid && (mq.size() < DEPTH);
      nb = m_busy;
      if (m_wen && m_mem) nb[m_rd] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd != 5'd0)) nb[bus.issue_rd] = 1'b1;
      sel = 1'b0;
      pop = 1'b0;
      srd = 5'd0;
      sd  = '0;
      if (bus.alu_valid) begin
         sel = 1'b1; srd = bus.alu_rd; sd = bus.alu_data;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         sel = 1'b1; pop = 1'b1; srd = e.rd; sd = e.data;
      end
      if (sel && (srd != 5'd0)) begin
         m_wen = 1'b1; m_mem = pop; m_rd = srd; m_res = sd;
      end else begin
         m_wen = 1'b0; m_mem = 1'b0;
      end
      if (push) mq.push_back('{rd: bus.mem_rd, data: bus.mem_data});
      m_busy = nb;
   endtask

   // One clock: update model at the edge, check registered outputs on the falling edge
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq("wen", 64'(bus.wen), 64'(m_wen));
      check_eq("rd", 64'(bus.rd), 64'(m_rd));
      check_eq("result", 64'(bus.result), 64'(m_res));
      check_eq("busy", 64'(bus.busy), 64'(m_busy));
   endtask

   task automatic step();
      comb_check();
      tick();
   endtask

   initial begin
      int r;
      int idx;
      n_checks = 0;
      n_errors = 0;
      mq.delete();
      pend.delete();
      m_busy = '0; m_wen = 1'b0; m_mem = 1'b0; m_rd = 5'd0; m_res = '0;
      rst = 1'b0;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);

      // Reset held with ALU traffic present
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h77;
      for (int i = 0; i < 2; i++) begin
         comb_check();
         check_eq("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
         tick();
         check_eq("rst_wen", 64'(bus.wen), 64'd0);
         check_eq("rst_busy", 64'(bus.busy), 64'd0);
      end
      rst = 1'b1;
      idle_inputs();
      comb_check();
      check_eq("post_rst_ready", 64'(bus.mem_ready), 64'd1);
      tick();

      // ALU path
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
      step();
      check_eq("alu_wen", 64'(bus.wen), 64'd1);
      check_eq("alu_rd", 64'(bus.rd), 64'd5);
      check_eq("alu_result", 64'(bus.result), 64'h1234);
      bus.alu_rd = 5'd0; bus.alu_data = 64'h99;
      step();
      check_eq("alu_x0_wen", 64'(bus.wen), 64'd0);
      check_eq("alu_x0_hold", 64'(bus.result), 64'h1234);

      // Load-use
      idle_inputs();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
      step();
      check_eq("lu_busy7", 64'(bus.busy[7]), 64'd1);
      idle_inputs();
      bus.rs1 = 5'd7;
      comb_check();
      check_eq("lu_hazard", 64'(bus.hazard), 64'd1);
      tick();
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 64'hDEAD;
      step();
      check_eq("lu_wen_early", 64'(bus.wen), 64'd0);
      bus.mem_valid = 1'b0;
      step();
      check_eq("lu_wen", 64'(bus.wen), 64'd1);
      check_eq("lu_rd", 64'(bus.rd), 64'd7);
      check_eq("lu_result", 64'(bus.result), 64'hDEAD);
      check_eq("lu_busy_still", 64'(bus.busy[7]), 64'd1);
      step();
      check_eq("lu_busy_clr", 64'(bus.busy[7]), 64'd0);
      comb_check();
      check_eq("lu_hazard_clr", 64'(bus.hazard), 64'd0);
      tick();

      // Backpressure: ALU stream blocks FIFO drain
      idle_inputs();
      for (int i = 11; i <= 13; i++) begin
         bus.issue_valid = 1'b1; bus.issue_rd = 5'(i);
         step();
      end
      idle_inputs();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd10;
      for (int i = 11; i <= 13; i++) begin
         bus.mem_valid = 1'b1; bus.mem_rd = 5'(i); bus.mem_data = 64'(i * 256);
         bus.alu_data = 64'(i);
         comb_check();
         check_eq("bp_ready", 64'(bus.mem_ready), (i == 13) ? 64'd0 : 64'd1);
         tick();
      end
      step();
      idle_inputs();
      step();
      check_eq("bp_first_rd", 64'(bus.rd), 64'd11);
      comb_check();
      check_eq("bp_ready_back", 64'(bus.mem_ready), 64'd1);
      tick();
      check_eq("bp_second_rd", 64'(bus.rd), 64'd12);
      check_eq("bp_second_res", 64'(bus.result), 64'd3072);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd13; bus.mem_data = 64'hD;
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) step();
      check_eq("bp_all_clear", 64'(bus.busy), 64'd0);

      // Set/clear collision on x9
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
      step();
      idle_inputs();
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 64'h99;
      step();
      idle_inputs();
      step();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
      step();
      check_eq("coll_busy9", 64'(bus.busy[9]), 64'd1);
      idle_inputs();
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 64'h9A;
      step();
      idle_inputs();
      for (int i = 0; i < 2; i++) step();
      check_eq("coll_clear", 64'(bus.busy[9]), 64'd0);

      // Load-use on x3 with write in the output stage
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      step();
      idle_inputs();
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 64'h55;
      step();
      idle_inputs();
      step();
      bus.rs2 = 5'd3;
      comb_check();
`ifdef WB_FWD_EN
      check_eq("fwd2_hit_x3", 64'(bus.fwd2_hit), 64'd1);
      check_eq("fwd2_data_x3", 64'(bus.fwd2_data), 64'h55);
      check_eq("fwd_hazard_x3", 64'(bus.hazard), 64'd0);
`else
      check_eq("nofwd_hazard_x3", 64'(bus.hazard), 64'd1);
`endif
      tick();
      idle_inputs();
      step();

      // Randomized traffic honouring the hazard contract
      for (int cyc = 0; cyc < 600; cyc++) begin
         idle_inputs();
         rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         if (!rst) begin
            pend.delete();
         end else begin
            if ((pend.size() > 0) && ($urandom_range(0, 1) == 1)) begin
               idx = $urandom_range(0, pend.size() - 1);
               bus.mem_valid = 1'b1;
               bus.mem_rd    = pend[idx];
               bus.mem_data  = {$urandom(), $urandom()};
               if (mq.size() < DEPTH) pend.delete(idx);
            end else if ($urandom_range(0, 7) == 0) begin
               bus.mem_valid = 1'b1;
               bus.mem_rd    = 5'd0;
               bus.mem_data  = {$urandom(), $urandom()};
            end
            if ($urandom_range(0, 2) == 0) begin
               r = $urandom_range(0, 31);
               if (!m_busy[r]) begin
                  bus.issue_valid = 1'b1;
                  bus.issue_rd    = 5'(r);
                  if (r != 0) pend.push_back(5'(r));
               end
            end
            if ($urandom_range(0, 9) < 4) begin
               r = $urandom_range(0, 31);
               if (m_busy[r] || (bus.issue_valid && (bus.issue_rd == 5'(r)))) r = 0;
               bus.alu_valid = 1'b1;
               bus.alu_rd    = 5'(r);
               bus.alu_data  = {$urandom(), $urandom()};
            end
         end
         bus.rs1    = 5'($urandom_range(0, 31));
         bus.rs2    = 5'($urandom_range(0, 31));
         bus.chk_rd = 5'($urandom_range(0, 31));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
